pong_core: RTL and testbench

Parametrised two-player Pong engine: successor to the fixed-geometry top-level game logic. It holds both paddles, a ball with size and speed, wall and paddle collisions on both sides, scoring, a serve delay and a win condition. It also renders ball, paddles and centre net from the VGA controller's pixel coordinates. It sits between the VGA timing controller (which supplies `vga_x`, `vga_y`, `video_on` and `frame_tick`) and the board RGB pins.

---
 rtl/pong_core.sv | 235 +++++++++++++++++++++++
 tb/tb_pong_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_core.sv
// pong_core: two-player Pong game state (paddles, ball, score, serve, win)
// plus a registered pixel renderer for ball, paddles and centre net.
module pong_core #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PADDLE_H     = 40,
  parameter int PADDLE_W     = 4,
  parameter int P1_X         = 40,
  parameter int P2_X         = 600,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SIZE    = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [9:0]         vga_x,
  input  logic [9:0]         vga_y,
  input  logic               video_on,
  input  logic               up_p1,
  input  logic               down_p1,
  input  logic               up_p2,
  input  logic               down_p2,
  input  logic               start,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_over,
  output logic               winner
);

  typedef enum logic [1:0] {S_SERVE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;

  localparam int CNT_W = $clog2(SERVE_FRAMES) + 1;
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SC_ONE     = SCORE_W'(1);
  // All geometry is carried at 11 bits so sums like x + size never wrap.
  localparam logic [10:0] HR    = 11'(H_RES);
  localparam logic [10:0] VR    = 11'(V_RES);
  localparam logic [10:0] BS    = 11'(BALL_SIZE);
  localparam logic [10:0] SPD   = 11'(BALL_SPEED);
  localparam logic [10:0] PSPD  = 11'(PADDLE_SPEED);
  localparam logic [10:0] PH    = 11'(PADDLE_H);
  localparam logic [10:0] PMAX  = 11'(V_RES - PADDLE_H);
  localparam logic [10:0] P1L   = 11'(P1_X);
  localparam logic [10:0] P1R   = 11'(P1_X + PADDLE_W);
  localparam logic [10:0] P2L   = 11'(P2_X);
  localparam logic [10:0] P2R   = 11'(P2_X + PADDLE_W);
  localparam logic [10:0] NET_L = 11'(H_RES / 2 - 1);
  localparam logic [10:0] NET_R = 11'(H_RES / 2);
  localparam logic [9:0]  XC    = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  YC    = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  PY0   = 10'((V_RES - PADDLE_H) / 2);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [9:0]           ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [9:0]           p1_y_q, p1_y_d, p2_y_q, p2_y_d;
  logic                 dx_q, dx_d;  // 1 = moving right
  logic                 dy_q, dy_d;  // 1 = moving down
  logic [SCORE_W-1:0]   s1_q, s1_d, s2_q, s2_d, s1_inc, s2_inc;
  logic                 winner_q, winner_d;
  logic [3:0]           pix_q, pix_d;

  logic [10:0] bx, by, p1w, p2w, vx, vy;
  logic        miss_l, miss_r, hit1, hit2, ball_px, pad_px, net_px;

  assign bx  = {1'b0, ball_x_q};
  assign by  = {1'b0, ball_y_q};
  assign p1w = {1'b0, p1_y_q};
  assign p2w = {1'b0, p2_y_q};
  assign vx  = {1'b0, vga_x};
  assign vy  = {1'b0, vga_y};

  assign miss_l = !dx_q && (bx < SPD);
  assign miss_r =  dx_q && (bx + BS > HR - SPD);
  // Paddle windows are SPD+1 wide so a ball stepping by SPD cannot skip one.
  assign hit1 = !dx_q && (bx >= P1R - SPD) && (bx <= P1R)
                && (by + BS > p1w) && (by < p1w + PH);
  assign hit2 =  dx_q && (bx + BS >= P2L - SPD) && (bx + BS <= P2L)
                && (by + BS > p2w) && (by < p2w + PH);

  assign s1_inc = (s1_q == WIN) ? s1_q : s1_q + SC_ONE;
  assign s2_inc = (s2_q == WIN) ? s2_q : s2_q + SC_ONE;

  function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up,
                                             input logic dn);
    logic [10:0] yw;
    yw = {1'b0, y};
    paddle_step = y;
    if (up && !dn)      paddle_step = (yw < PSPD) ? 10'd0 : 10'(yw - PSPD);
    else if (dn && !up) paddle_step = (yw + PSPD > PMAX) ? 10'(PMAX) : 10'(yw + PSPD);
  endfunction

  // Game next-state: paddles, serve counter, ball motion, scoring, restart.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    p1_y_d   = p1_y_q;
    p2_y_d   = p2_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    winner_d = winner_q;
    if (frame_tick) begin
      p1_y_d = paddle_step(p1_y_q, up_p1, down_p1);
      p2_y_d = paddle_step(p2_y_q, up_p2, down_p2);
      case (state_q)
        S_SERVE: begin
          ball_x_d = XC;
          ball_y_d = YC;
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = S_PLAY;
            dy_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_PLAY: begin
          if (!dy_q && by <= SPD) begin
            ball_y_d = 10'd0;
            dy_d     = 1'b1;
          end else if (dy_q && by + BS >= VR - SPD) begin
            ball_y_d = 10'(VR - BS);
            dy_d     = 1'b0;
          end else begin
            ball_y_d = dy_q ? 10'(by + SPD) : 10'(by - SPD);
          end
          // A point overrides the vertical step: the ball recentres.
          if (miss_l || miss_r) begin
            ball_x_d = XC;
            ball_y_d = YC;
            cnt_d    = '0;
            dx_d     = miss_l;
            state_d  = S_SERVE;
            if (miss_l) begin
              s2_d = s2_inc;
              if (s2_inc == WIN) begin state_d = S_OVER; winner_d = 1'b1; end
            end else begin
              s1_d = s1_inc;
              if (s1_inc == WIN) begin state_d = S_OVER; winner_d = 1'b0; end
            end
          end else if (hit1) begin
            ball_x_d = 10'(P1R);
            dx_d     = 1'b1;
          end else if (hit2) begin
            ball_x_d = 10'(P2L - BS);
            dx_d     = 1'b0;
          end else begin
            ball_x_d = dx_q ? 10'(bx + SPD) : 10'(bx - SPD);
          end
        end
        S_OVER: begin
          ball_x_d = XC;
          ball_y_d = YC;
          if (start) begin
            s1_d     = '0;
            s2_d     = '0;
            winner_d = 1'b0;
            dx_d     = 1'b1;
            cnt_d    = '0;
            state_d  = S_SERVE;
          end
        end
        default: state_d = S_SERVE;
      endcase
    end
  end

  assign ball_px = (vx >= bx) && (vx < bx + BS) && (vy >= by) && (vy < by + BS);
  assign pad_px  = ((vx >= P1L) && (vx < P1R) && (vy >= p1w) && (vy < p1w + PH)) ||
                   ((vx >= P2L) && (vx < P2R) && (vy >= p2w) && (vy < p2w + PH));
  assign net_px  = ((vx == NET_L) || (vx == NET_R)) && !vga_y[3];

  // Pixel colour with ball > paddle > net priority, blanked outside video.
  always_comb begin
    pix_d = 4'h0;
    if (video_on) begin
      if (ball_px)     pix_d = 4'hF;
      else if (pad_px) pix_d = 4'hF;
      else if (net_px) pix_d = 4'h8;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_SERVE;
      cnt_q    <= '0;
      ball_x_q <= XC;
      ball_y_q <= YC;
      p1_y_q   <= PY0;
      p2_y_q   <= PY0;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      s1_q     <= '0;
      s2_q     <= '0;
      winner_q <= 1'b0;
      pix_q    <= 4'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      p1_y_q   <= p1_y_d;
      p2_y_q   <= p2_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      winner_q <= winner_d;
      pix_q    <= pix_d;
    end
  end

  assign red       = pix_q;
  assign green     = pix_q;
  assign blue      = pix_q;
  assign score_p1  = s1_q;
  assign score_p2  = s2_q;
  assign game_over = (state_q == S_OVER);
  assign winner    = winner_q;

endmodule

// File: tb/tb_pong_core.sv
// tb_pong_core: directed checks of pong_core with hand-traced ball paths.
module tb_pong_core;

  logic       clk = 1'b0;
  logic       reset, frame_tick, video_on, start;
  logic       up_p1, down_p1, up_p2, down_p2;
  logic [9:0] vga_x, vga_y;
  logic [3:0] red, green, blue;
  logic [3:0] score_p1, score_p2;
  logic       game_over, winner;

  int n_cmp = 0;
  int n_err = 0;

  pong_core dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .vga_x(vga_x), .vga_y(vga_y), .video_on(video_on),
    .up_p1(up_p1), .down_p1(down_p1), .up_p2(up_p2), .down_p2(down_p2),
    .start(start), .red(red), .green(green), .blue(blue),
    .score_p1(score_p1), .score_p2(score_p2),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic [3:0] pix;
  } rvec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_ball(input string name, input int x, input int y);
    chk({name, ".x"}, int'(dut.ball_x_q), x);
    chk({name, ".y"}, int'(dut.ball_y_q), y);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  rvec_t vt[17];

  initial begin
    vt[0]  = '{10'd318, 10'd238, 1'b1, 4'hF};
    vt[1]  = '{10'd321, 10'd241, 1'b1, 4'hF};
    vt[2]  = '{10'd322, 10'd238, 1'b1, 4'h0};
    vt[3]  = '{10'd318, 10'd238, 1'b0, 4'h0};
    vt[4]  = '{10'd319, 10'd240, 1'b1, 4'hF};
    vt[5]  = '{10'd320, 10'd242, 1'b1, 4'h8};
    vt[6]  = '{10'd319, 10'd16,  1'b1, 4'h8};
    vt[7]  = '{10'd320, 10'd24,  1'b1, 4'h0};
    vt[8]  = '{10'd319, 10'd0,   1'b1, 4'h8};
    vt[9]  = '{10'd40,  10'd220, 1'b1, 4'hF};
    vt[10] = '{10'd43,  10'd259, 1'b1, 4'hF};
    vt[11] = '{10'd44,  10'd230, 1'b1, 4'h0};
    vt[12] = '{10'd40,  10'd260, 1'b1, 4'h0};
    vt[13] = '{10'd603, 10'd220, 1'b1, 4'hF};
    vt[14] = '{10'd599, 10'd240, 1'b1, 4'h0};
    vt[15] = '{10'd600, 10'd219, 1'b1, 4'h0};
    vt[16] = '{10'd319, 10'd0,   1'b0, 4'h0};

    reset = 1'b1; frame_tick = 1'b0; video_on = 1'b0; start = 1'b0;
    up_p1 = 1'b0; down_p1 = 1'b0; up_p2 = 1'b0; down_p2 = 1'b0;
    vga_x = 10'd0; vga_y = 10'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst.score_p1", int'(score_p1), 0);
    chk("rst.score_p2", int'(score_p2), 0);
    chk("rst.game_over", int'(game_over), 0);
    chk("rst.winner", int'(winner), 0);
    chk("rst.rgb", int'({red, green, blue}), 0);
    chk_ball("rst.ball", 318, 238);
    chk("rst.p1_y", int'(dut.p1_y_q), 220);
    chk("rst.p2_y", int'(dut.p2_y_q), 220);

    // Rendering table against the static reset scene
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      vga_x = vt[i].x; vga_y = vt[i].y; video_on = vt[i].von;
      @(negedge clk);
      chk($sformatf("pix%0d.r", i), int'(red),   int'(vt[i].pix));
      chk($sformatf("pix%0d.g", i), int'(green), int'(vt[i].pix));
      chk($sformatf("pix%0d.b", i), int'(blue),  int'(vt[i].pix));
    end
    video_on = 1'b0;

    // Serve delay: 60 ticks held, first move on tick 61
    ticks(60);
    chk_ball("serve60", 318, 238);
    tick();
    chk_ball("serve61", 320, 240);
    chk("serve61.score", int'({score_p1, score_p2}), 0);
    chk("serve61.over", int'(game_over), 0);

    // Paddle movement and clamps
    do_reset();
    up_p1 = 1'b1; down_p1 = 1'b1;
    ticks(5);
    chk("pad.both", int'(dut.p1_y_q), 220);
    down_p1 = 1'b0;
    ticks(10);
    chk("pad.up10", int'(dut.p1_y_q), 180);
    ticks(50);
    chk("pad.up_clamp", int'(dut.p1_y_q), 0);
    up_p1 = 1'b0; down_p1 = 1'b1;
    ticks(120);
    chk("pad.dn_clamp", int'(dut.p1_y_q), 440);
    down_p1 = 1'b0;

    // Paddle 2 return, then paddle 1 return
    do_reset();
    for (int t = 0; t < 60; t++) begin
      down_p2 = (t < 45);
      tick();
    end
    chk("hit.p2_y", int'(dut.p2_y_q), 400);
    ticks(138);
    chk_ball("hit2.pre", 594, 438);
    tick();
    chk_ball("hit2", 596, 436);
    chk("hit2.dx", int'(dut.dx_q), 0);
    for (int t = 0; t < 276; t++) begin
      up_p1 = (t < 30);
      tick();
    end
    up_p1 = 1'b0;
    chk("hit.p1_y", int'(dut.p1_y_q), 100);
    chk_ball("hit1.pre", 44, 116);
    chk("hit1.pre_dx", int'(dut.dx_q), 0);
    tick();
    chk_ball("hit1", 44, 118);
    chk("hit1.dx", int'(dut.dx_q), 1);
    chk("hit.scores", int'({score_p1, score_p2}), 0);

    // Ball passes under a parked paddle 2: player 1 scores
    do_reset();
    for (int t = 0; t < 60; t++) begin
      up_p2 = (t < 55);
      tick();
    end
    up_p2 = 1'b0;
    chk("miss.p2_y", int'(dut.p2_y_q), 0);
    ticks(159);
    chk("miss.pre_x", int'(dut.ball_x_q), 636);
    chk("miss.pre_score", int'(score_p1), 0);
    tick();
    chk("miss.score_p1", int'(score_p1), 1);
    chk_ball("miss.centre", 318, 238);
    chk("miss.dx", int'(dut.dx_q), 0);
    ticks(60);
    chk_ball("miss.hold", 318, 238);
    tick();
    chk_ball("miss.serve", 316, 240);

    // Reset mid-rally
    @(negedge clk);
    vga_x = 10'd316; vga_y = 10'd240; video_on = 1'b1;
    @(negedge clk);
    chk("mid.rgb_ball", int'(red), 15);
    reset = 1'b1;
    @(negedge clk);
    chk("mid.rgb", int'({red, green, blue}), 0);
    chk("mid.score_p1", int'(score_p1), 0);
    chk("mid.over", int'(game_over), 0);
    chk_ball("mid.ball", 318, 238);
    chk("mid.p2_y", int'(dut.p2_y_q), 220);
    reset = 1'b0; video_on = 1'b0;

    // Player 2 wins 9 rallies: p2 returns at y 400, p1 parked at 0 misses
    for (int r = 0; r < 9; r++) begin
      for (int t = 0; t < 498; t++) begin
        up_p1   = (r == 0) && (t < 55);
        down_p2 = (r == 0) && (t < 45);
        start   = ((r == 1) && (t == 10)) || ((r == 8) && (t == 100));
        if (t == 497) chk($sformatf("win%0d.pre", r), int'(score_p2), r);
        tick();
      end
      start = 1'b0;
      chk($sformatf("win%0d.score_p2", r), int'(score_p2), r + 1);
      chk($sformatf("win%0d.over", r), int'(game_over), int'(r == 8));
    end
    chk("over.winner", int'(winner), 1);
    chk("over.score_p1", int'(score_p1), 0);
    ticks(3);
    chk("over.hold", int'(game_over), 1);
    chk_ball("over.ball", 318, 238);

    // Restart from OVER
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart.scores", int'({score_p1, score_p2}), 0);
    chk("restart.winner", int'(winner), 0);
    chk("restart.over", int'(game_over), 0);
    chk("restart.dx", int'(dut.dx_q), 1);
    ticks(60);
    chk_ball("restart.hold", 318, 238);
    tick();
    chk_ball("restart.move", 320, 240);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
